// File: rtl/iob_iob2axi_write_pkg.sv
// rtl/iob_iob2axi_write_pkg.sv - shared FSM encoding and AXI constants for the IOb-to-AXI write bridge
package iob_iob2axi_write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR_HS = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [3:0] AXI_CACHE_MODIFY   = 4'b0010;
  localparam logic [2:0] AXI_PROT_NONSECURE = 3'b010;

  // AXI awsize encoding for a full-width beat of data_w bits
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/iob_iob2axi_write_buf.sv
// rtl/iob_iob2axi_write_buf.sv - two-entry FIFO between IOb read data and AXI W channel
module iob_iob2axi_write_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        level_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        level_q, level_d;
  logic              do_push, do_pop;

  assign full_o     = (level_q == 2'd2);
  assign empty_o    = (level_q == 2'd0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted when the same cycle pops, so occupancy stays put
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/iob_iob2axi_write.sv
// rtl/iob_iob2axi_write.sv - reads a burst over IOb and writes it out as one AXI4 write burst
module iob_iob2axi_write
  import iob_iob2axi_write_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int AXI_ID_W    = 1,
  parameter int AXI_BURST_W = 2,
  parameter int AXI_LOCK_W  = 2,
  parameter int AXI_CACHE_W = 4,
  parameter int AXI_PROT_W  = 3,
  parameter int AXI_QOS_W   = 4,
  parameter int AXI_RESP_W  = 2
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  // control
  input  logic                   run_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [AXI_LEN_W-1:0]   length_i,
  output logic                   ready_o,
  output logic                   error_o,
  // IOb read master
  output logic                   m_iob_valid_o,
  output logic [ADDR_W-1:0]      m_iob_addr_o,
  output logic [DATA_W-1:0]      m_iob_wdata_o,
  output logic [DATA_W/8-1:0]    m_iob_wstrb_o,
  input  logic                   m_iob_ready_i,
  input  logic                   m_iob_rvalid_i,
  input  logic [DATA_W-1:0]      m_iob_rdata_i,
  // AXI write address
  output logic [AXI_ID_W-1:0]    m_axi_awid_o,
  output logic [ADDR_W-1:0]      m_axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]   m_axi_awlen_o,
  output logic [2:0]             m_axi_awsize_o,
  output logic [AXI_BURST_W-1:0] m_axi_awburst_o,
  output logic [AXI_LOCK_W-1:0]  m_axi_awlock_o,
  output logic [AXI_CACHE_W-1:0] m_axi_awcache_o,
  output logic [AXI_PROT_W-1:0]  m_axi_awprot_o,
  output logic [AXI_QOS_W-1:0]   m_axi_awqos_o,
  output logic                   m_axi_awvalid_o,
  input  logic                   m_axi_awready_i,
  // AXI write data
  output logic [DATA_W-1:0]      m_axi_wdata_o,
  output logic [DATA_W/8-1:0]    m_axi_wstrb_o,
  output logic                   m_axi_wlast_o,
  output logic                   m_axi_wvalid_o,
  input  logic                   m_axi_wready_i,
  // AXI write response
  input  logic [AXI_ID_W-1:0]    m_axi_bid_i,
  input  logic [AXI_RESP_W-1:0]  m_axi_bresp_i,
  input  logic                   m_axi_bvalid_i,
  output logic                   m_axi_bready_o
);

  localparam int ADDR_SHIFT = $clog2(DATA_W / 8);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [AXI_LEN_W-1:0]  len_q, len_d;
  logic [AXI_LEN_W-1:0]  req_cnt_q, req_cnt_d;
  logic                  req_done_q, req_done_d;
  logic [AXI_LEN_W-1:0]  sent_cnt_q, sent_cnt_d;
  logic [1:0]            inflight_q, inflight_d;
  logic                  error_q, error_d;

  logic                  start;
  logic                  reading;
  logic                  can_req;
  logic                  iob_accept;
  logic                  buf_push;
  logic                  buf_full;
  logic                  buf_empty;
  logic [1:0]            buf_level;
  logic [DATA_W-1:0]     buf_head;
  logic                  w_fire;
  logic                  w_is_last;
  logic                  unused_inputs;

  assign unused_inputs = ^{m_axi_bid_i, buf_full};

  assign start   = (state_q == ST_IDLE) && run_i;
  assign reading = (state_q == ST_ADDR_HS) || (state_q == ST_WRITE);

  // Reads in flight plus buffered words never exceed the two FIFO slots, so every
  // response has somewhere to land. The sum only drops via pops, which keeps a raised
  // request stable until it is accepted.
  assign can_req    = ({1'b0, buf_level} + {1'b0, inflight_q}) < 3'd2;
  assign iob_accept = m_iob_valid_o && m_iob_ready_i;
  // Stray responses after an abandoned burst are dropped while idle
  assign buf_push   = m_iob_rvalid_i && (state_q != ST_IDLE);

  assign m_iob_valid_o = reading && !req_done_q && can_req;
  assign m_iob_addr_o  = addr_q + (ADDR_W'(req_cnt_q) << ADDR_SHIFT);
  assign m_iob_wdata_o = '0;
  assign m_iob_wstrb_o = '0;

  assign m_axi_awid_o    = '0;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = len_q;
  assign m_axi_awsize_o  = axi_size(DATA_W);
  assign m_axi_awburst_o = AXI_BURST_W'(AXI_BURST_INCR);
  assign m_axi_awlock_o  = '0;
  assign m_axi_awcache_o = AXI_CACHE_W'(AXI_CACHE_MODIFY);
  assign m_axi_awprot_o  = AXI_PROT_W'(AXI_PROT_NONSECURE);
  assign m_axi_awqos_o   = '0;
  assign m_axi_awvalid_o = (state_q == ST_ADDR_HS);

  assign m_axi_wvalid_o = (state_q == ST_WRITE) && !buf_empty;
  assign m_axi_wdata_o  = buf_head;
  assign m_axi_wstrb_o  = '1;
  assign w_is_last      = (sent_cnt_q == len_q);
  assign m_axi_wlast_o  = m_axi_wvalid_o && w_is_last;
  assign w_fire         = m_axi_wvalid_o && m_axi_wready_i;

  assign m_axi_bready_o = (state_q == ST_RESP);

  assign ready_o = (state_q == ST_IDLE);
  assign error_o = error_q;

  iob_iob2axi_write_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .push_i     (buf_push),
    .push_data_i(m_iob_rdata_i),
    .pop_i      (w_fire),
    .pop_data_o (buf_head),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .level_o    (buf_level)
  );

  // Burst sequencing: address handshake, data beats, then the write response
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (run_i) state_d = ST_ADDR_HS;
      ST_ADDR_HS: if (m_axi_awready_i) state_d = ST_WRITE;
      ST_WRITE:   if (w_fire && w_is_last) state_d = ST_RESP;
      ST_RESP:    if (m_axi_bvalid_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Burst parameters, request/beat counters and error status next-state
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    req_done_d = req_done_q;
    sent_cnt_d = sent_cnt_q;
    inflight_d = inflight_q;
    error_d    = error_q;

    if (start) begin
      addr_d     = addr_i;
      len_d      = length_i;
      req_cnt_d  = '0;
      req_done_d = 1'b0;
      sent_cnt_d = '0;
      inflight_d = 2'd0;
      error_d    = 1'b0;
    end

    // The done flag, not the counter, ends requesting, so a full-range length
    // may let the counter wrap harmlessly
    if (iob_accept) begin
      req_cnt_d = req_cnt_q + AXI_LEN_W'(1);
      if (req_cnt_q == len_q) req_done_d = 1'b1;
    end

    case ({iob_accept, buf_push})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = (inflight_q != 2'd0) ? inflight_q - 2'd1 : 2'd0;
      default: inflight_d = inflight_q;
    endcase

    if (w_fire) sent_cnt_d = sent_cnt_q + AXI_LEN_W'(1);

    if ((state_q == ST_RESP) && m_axi_bvalid_i) error_d = |m_axi_bresp_i;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_q     <= '0;
      len_q      <= '0;
      req_cnt_q  <= '0;
      req_done_q <= 1'b0;
      sent_cnt_q <= '0;
      inflight_q <= 2'd0;
      error_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      req_done_q <= req_done_d;
      sent_cnt_q <= sent_cnt_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_iob_iob2axi_write.sv
// tb/tb_iob_iob2axi_write.sv - self-checking bench for iob_iob2axi_write
module tb_iob_iob2axi_write;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        run_i;
  logic [31:0] addr_i;
  logic [7:0]  length_i;
  logic        ready_o, error_o;
  logic        iob_valid, iob_ready, iob_rvalid;
  logic [31:0] iob_addr, iob_wdata, iob_rdata;
  logic [3:0]  iob_wstrb;
  logic [0:0]  awid, bid;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic [3:0]  awcache, awqos, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  iob_iob2axi_write dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .run_i(run_i), .addr_i(addr_i), .length_i(length_i), .ready_o(ready_o), .error_o(error_o),
    .m_iob_valid_o(iob_valid), .m_iob_addr_o(iob_addr), .m_iob_wdata_o(iob_wdata),
    .m_iob_wstrb_o(iob_wstrb), .m_iob_ready_i(iob_ready), .m_iob_rvalid_i(iob_rvalid),
    .m_iob_rdata_i(iob_rdata),
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
    .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock), .m_axi_awcache_o(awcache),
    .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos), .m_axi_awvalid_o(awvalid),
    .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast), .m_axi_wvalid_o(wvalid),
    .m_axi_wready_i(wready),
    .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
  );

  int vectors = 0;
  int miscompares = 0;

  // slave behaviour knobs
  int aw_pct = 100, w_pct = 100, iob_pct = 100, b_pct = 100;
  int lat_min = 1, lat_max = 1;
  int stall_after = -1, stall_left = 0;
  logic [1:0] cfg_bresp = 2'd0;

  // observation records
  typedef struct { int unsigned due; logic [31:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  logic [31:0] req_addrs[$];
  logic [31:0] w_data[$];
  logic        w_last[$];
  int          aw_cnt, b_cnt, outstanding, max_out, viol, strb_bad, iob_const_bad;
  logic [31:0] aw_addr_s;
  logic [7:0]  aw_len_s;
  logic [2:0]  aw_size_s, aw_prot_s;
  logic [1:0]  aw_burst_s;
  logic [3:0]  aw_cache_s;
  logic [6:0]  aw_misc_s;
  int unsigned cyc = 0, last_due = 0;
  logic        aw_pend = 1'b0, iob_pend = 1'b0;
  logic [31:0] iob_pend_addr = '0;

  // memory contents the IOb slave returns for a given byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_records();
    req_addrs.delete(); w_data.delete(); w_last.delete();
    aw_cnt = 0; b_cnt = 0; outstanding = 0; max_out = 0; viol = 0;
    strb_bad = 0; iob_const_bad = 0;
  endtask

  // Slave side: drive ready/response inputs each negedge and log what handshakes
  // the following posedge will complete (DUT outputs depend only on its registers)
  initial begin
    awready = 0; wready = 0; iob_ready = 0; iob_rvalid = 0; iob_rdata = '0;
    bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!arst_n) begin
        rsp_q.delete(); last_due = cyc; outstanding = 0;
        aw_pend = 0; iob_pend = 0;
        awready = 0; wready = 0; iob_ready = 0; iob_rvalid = 0; bvalid = 0;
      end else begin
        awready   = rnd(aw_pct);
        iob_ready = rnd(iob_pct);
        if (stall_left > 0 && stall_after >= 0 && w_data.size() >= stall_after) begin
          wready = 1'b0;
          stall_left--;
        end else begin
          wready = rnd(w_pct);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          iob_rvalid = 1'b1;
          iob_rdata  = rsp_q[0].data;
          void'(rsp_q.pop_front());
        end else begin
          iob_rvalid = 1'b0;
          iob_rdata  = $urandom;
        end
        bvalid = bready && rnd(b_pct);
        bresp  = cfg_bresp;

        if (aw_pend && !awvalid) viol++;
        aw_pend = awvalid && !awready;
        if (awvalid && awready) begin
          aw_cnt++;
          aw_addr_s = awaddr; aw_len_s = awlen; aw_size_s = awsize; aw_burst_s = awburst;
          aw_cache_s = awcache; aw_prot_s = awprot; aw_misc_s = {awid, awlock, awqos};
        end

        if (iob_pend && (!iob_valid || iob_addr != iob_pend_addr)) viol++;
        iob_pend = iob_valid && !iob_ready;
        iob_pend_addr = iob_addr;
        if (iob_valid && (iob_wdata != 0 || iob_wstrb != 0)) iob_const_bad++;
        if (iob_valid && iob_ready) begin
          int unsigned due;
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rsp_q.push_back('{due, mem_word(iob_addr)});
          req_addrs.push_back(iob_addr);
          outstanding++;
        end

        if (wvalid && wready) begin
          w_data.push_back(wdata);
          w_last.push_back(wlast);
          if (wstrb != 4'hF) strb_bad++;
          outstanding--;
        end
        if (outstanding > max_out) max_out = outstanding;
        if (bvalid && bready) b_cnt++;
      end
    end
  end

  task automatic check_burst(input logic [31:0] a, input int len, input logic [1:0] br);
    int n;
    chk("aw_count", aw_cnt, 1);
    chk("aw_addr", aw_addr_s, a);
    chk("aw_len", aw_len_s, len);
    chk("aw_size", aw_size_s, 2);
    chk("aw_burst", aw_burst_s, 1);
    chk("aw_cache", aw_cache_s, 2);
    chk("aw_prot", aw_prot_s, 2);
    chk("aw_id_lock_qos", aw_misc_s, 0);
    chk("w_beats", w_data.size(), len + 1);
    chk("iob_reqs", req_addrs.size(), len + 1);
    n = (w_data.size() < req_addrs.size()) ? w_data.size() : req_addrs.size();
    for (int i = 0; i < n; i++) begin
      logic [31:0] ea;
      ea = a + 32'(4 * i);
      chk("iob_addr", req_addrs[i], ea);
      chk("wdata", w_data[i], mem_word(ea));
      chk("wlast", w_last[i], (i == len));
    end
    chk("b_count", b_cnt, 1);
    chk("error_o", error_o, (br != 2'd0));
    chk("ready_o_end", ready_o, 1);
    chk("max_outstanding_le2", (max_out <= 2), 1);
    chk("handshake_stability", viol, 0);
    chk("wstrb_ones", strb_bad, 0);
    chk("iob_wdata_wstrb_zero", iob_const_bad, 0);
  endtask

  task automatic start_burst(input logic [31:0] a, input int len);
    int t;
    t = 0;
    while (!ready_o && t < 1000) begin @(negedge clk); t++; end
    if (!ready_o) chk("ready_timeout", 0, 1);
    addr_i = a; length_i = 8'(len); run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    chk("ready_drop", ready_o, 0);
    chk("error_cleared", error_o, 0);
  endtask

  task automatic do_burst(input logic [31:0] a, input int len, input logic [1:0] br, input bit inject);
    bit injected;
    injected = 0;
    clear_records();
    cfg_bresp = br;
    start_burst(a, len);
    for (int t = 0; t < 20000 && b_cnt == 0; t++) begin
      @(negedge clk);
      if (inject && !injected && wvalid) begin
        run_i = 1'b1; addr_i = 32'hDEAD_0000; length_i = 8'd5; injected = 1;
      end else begin
        run_i = 1'b0;
      end
    end
    run_i = 1'b0;
    if (b_cnt == 0) chk("b_timeout", 0, 1);
    @(negedge clk);
    check_burst(a, len, br);
  endtask

  initial begin
    int snap_w, snap_aw;
    arst_n = 1'b0; run_i = 1'b0; addr_i = '0; length_i = '0;
    clear_records();
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_error", error_o, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_iob_valid", iob_valid, 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic burst and single-beat burst with always-ready slaves
    do_burst(32'h0000_0100, 3, 2'd0, 0);
    do_burst(32'h0000_0200, 0, 2'd0, 0);

    // wready held low for 5 cycles after two beats
    stall_after = 2; stall_left = 5;
    do_burst(32'h0000_0300, 7, 2'd0, 0);
    chk("stall_consumed", stall_left, 0);
    stall_after = -1; stall_left = 0;

    // SLVERR response, with a run pulse during WRITE that must be ignored
    do_burst(32'h0000_0400, 7, 2'd2, 1);
    repeat (5) @(negedge clk);
    chk("error_sticky", error_o, 1);
    do_burst(32'h0000_0500, 2, 2'd0, 0);

    // asynchronous reset in the middle of a burst
    clear_records();
    start_burst(32'h0000_2000, 7);
    for (int t = 0; t < 2000 && !(w_data.size() >= 2 && wvalid); t++) @(negedge clk);
    chk("reach_beat3", (w_data.size() >= 2), 1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_awvalid", awvalid, 0);
    chk("arst_wvalid", wvalid, 0);
    chk("arst_iob_valid", iob_valid, 0);
    chk("arst_bready", bready, 0);
    chk("arst_ready", ready_o, 1);
    snap_w = w_data.size(); snap_aw = aw_cnt;
    repeat (3) @(negedge clk);
    chk("arst_no_w", w_data.size(), snap_w);
    chk("arst_no_aw", aw_cnt, snap_aw);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_burst(32'h0000_3000, 1, 2'd0, 0);

    // full-length burst and random bursts under random backpressure and latency
    aw_pct = 50; w_pct = 60; iob_pct = 50; b_pct = 40; lat_min = 1; lat_max = 4;
    do_burst(32'h0000_1000, 255, 2'd0, 0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'h000F_F000) | 32'(4 * $urandom_range(0, 255));
      do_burst(ra & 32'hFFFF_FC00, $urandom_range(0, 255), 2'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_iob2axi_write.md
IOB_IOB2AXI_WRITE -- requirements
Module: iob_iob2axi_write

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of the IOb and AXI sides.
REQ-002 SHALL have parameter DATA_W, default 32: data width, a power of two of at least 8.
REQ-003 SHALL have parameters AXI_LEN_W 8, AXI_ID_W 1, AXI_BURST_W 2, AXI_LOCK_W 2, AXI_CACHE_W 4, AXI_PROT_W 3, AXI_QOS_W 4, AXI_RESP_W 2: AXI field widths.
REQ-004 SHALL have ports clk_i (in, 1, clock) and arst_n_i (in, 1): one clock; reset is asynchronous and active-low.
REQ-005 SHALL have control ports: run_i (in, 1, start pulse), addr_i (in, ADDR_W, byte address), length_i (in, AXI_LEN_W, beats-1), ready_o (out, 1, idle), error_o (out, 1, last burst failed).
REQ-006 SHALL have IOb read-master ports: m_iob_valid_o (out, 1), m_iob_addr_o (out, ADDR_W), m_iob_wdata_o (out, DATA_W, constant 0), m_iob_wstrb_o (out, DATA_W/8, constant 0), m_iob_ready_i (in, 1), m_iob_rvalid_i (in, 1), m_iob_rdata_i (in, DATA_W).
REQ-007 SHALL have full AXI4 write-master ports: aw* (id, addr, len, size, burst, lock, cache, prot, qos, valid out; ready in), w* (data, strb, last, valid out; ready in) and b* (id, resp, valid in; ready out).

Function
REQ-008 SHALL implement the FSM IDLE -> ADDR_HS -> WRITE -> RESP -> IDLE.
REQ-009 In IDLE, ready_o SHALL be 1; run_i SHALL latch addr_i/length_i, clear error_o, and enter ADDR_HS; ready_o SHALL drop the next cycle.
REQ-010 run_i outside IDLE SHALL be ignored.
REQ-011 In ADDR_HS, awvalid SHALL be 1 with latched addr/len; on awready the FSM SHALL enter WRITE; awvalid is never withdrawn before awready.
REQ-012 AW constants: awid 0, awsize clog2(DATA_W/8), awburst 1 (INCR), awlock 0, awcache 2, awprot 2, awqos 0. wstrb SHALL be all ones.
REQ-013 IOb reads SHALL start in ADDR_HS; m_iob_addr_o = addr_reg + req_cnt*(DATA_W/8); exactly length+1 requests per burst.
REQ-014 A request SHALL be issued only while (buffer occupancy + reads in flight) < 2; m_iob_valid_o SHALL be held stable until m_iob_ready_i.
REQ-015 Each m_iob_rvalid_i SHALL push m_iob_rdata_i into a 2-entry FIFO; responses are in order, at least 1 cycle after acceptance.
REQ-016 In WRITE, wvalid SHALL equal FIFO not-empty; wdata is the FIFO head; a wvalid&wready beat SHALL pop and increment sent_cnt.
REQ-017 wlast SHALL be 1 exactly on the beat with sent_cnt == length_reg; that beat SHALL move the FSM to RESP.
REQ-018 A simultaneous FIFO push and pop SHALL keep occupancy unchanged with no data loss.
REQ-019 In RESP, bready SHALL be 1; on bvalid error_o SHALL be registered as |bresp, and the FSM SHALL return to IDLE.
REQ-020 Counters SHALL be AXI_LEN_W bits; a request-done flag SHALL cover length_i = 2^AXI_LEN_W-1 without wrap.
REQ-021 Bursts SHALL NOT be split; not crossing 4 KB is a caller constraint.

Reset
REQ-022 On arst_n_i low (any state, async): IDLE; ready_o 1; error_o 0; all valids/bready 0; counters, FIFO, addr/len registers 0.
REQ-023 Reset mid-burst SHALL abandon the transaction with no further AXI or IOb activity.

Structure
REQ-024 FSM state encodings and the AXI constants (INCR, cache 2, prot 2) SHALL live in the shared iob2axi package/header.
REQ-025 The FIFO SHALL be sub-module iob_iob2axi_write_buf (2 entries; push, pop, full, empty, level).

Verification
REQ-026 addr 0x100, len 3, always-ready slaves, 1-cycle IOb latency -> AW 0x100/len 3/size 2; W 4 beats from 0x100..0x10C, wlast on beat 4; bresp 0 -> error_o 0, ready_o 1.
REQ-027 len 0 -> one beat with wlast=1; then BRESP handling.
REQ-028 wready low 5 cycles mid-burst, len 7 -> at most 2 IOb reads outstanding/buffered; no data lost or duplicated; order preserved.
REQ-029 bresp=2 (SLVERR) -> error_o 1 until the next run_i; run_i during WRITE ignored.
REQ-030 arst_n_i asserted during beat 3 of len 7 -> all valids 0 asynchronously; after release a fresh len-1 burst completes correctly.
REQ-031 len 255 with random awready/wready/m_iob_ready/latency -> 256 beats, addresses incrementing by 4, single wlast.
